// File: rtl/core_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// core_irq_ctrl_if
// Register-slave bus between software (data-bus side) and core_irq_ctrl.
// Signals:
//   reg_req_i    master->slave  access request
//   reg_gnt_o    slave->master  grant (same cycle as request)
//   reg_rvalid_o slave->master  response valid, one cycle after each grant
//   reg_addr_i   master->slave  byte address, bits [3:2] select the word
//   reg_we_i     master->slave  write enable
//   reg_wdata_i  master->slave  write data
//   reg_rdata_o  slave->master  read data, valid with reg_rvalid_o
// ---------------------------------------------------------------------------
interface core_irq_ctrl_if;
  logic        reg_req_i;
  logic        reg_gnt_o;
  logic        reg_rvalid_o;
  logic [3:0]  reg_addr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;

  modport master (
    output reg_req_i, reg_addr_i, reg_we_i, reg_wdata_i,
    input  reg_gnt_o, reg_rvalid_o, reg_rdata_o
  );

  modport slave (
    input  reg_req_i, reg_addr_i, reg_we_i, reg_wdata_i,
    output reg_gnt_o, reg_rvalid_o, reg_rdata_o
  );
endinterface

// File: rtl/core_irq_ctrl.sv
// ---------------------------------------------------------------------------
// core_irq_ctrl
// Interrupt controller feeding the core's irq/irq_id inputs. Each source is
// synchronised, optionally edge-detected into a pending bit, masked, and the
// highest active index is presented as a registered request.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   irq_i           raw interrupt sources (N_IRQ)
//   irq_o           registered request to core
//   irq_id_o        registered id of highest-index active source
//   irq_ack_i       one-cycle acknowledge from core
//   irq_ack_id_i    id being acknowledged
//   bus             register slave (PENDING/MASK/EDGE/SET)
// ---------------------------------------------------------------------------
module core_irq_ctrl #(
  parameter int                N_IRQ       = 32,
  parameter int                ID_WIDTH    = 5,
  parameter int                SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0]  MASK_RESET  = '1,
  parameter logic [N_IRQ-1:0]  EDGE_RESET  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_IRQ-1:0]    irq_i,
  output logic                irq_o,
  output logic [ID_WIDTH-1:0] irq_id_o,
  input  logic                irq_ack_i,
  input  logic [ID_WIDTH-1:0] irq_ack_id_i,
  core_irq_ctrl_if.slave      bus
);

  localparam logic [1:0] W_PENDING = 2'd0;
  localparam logic [1:0] W_MASK    = 2'd1;
  localparam logic [1:0] W_EDGE    = 2'd2;
  localparam logic [1:0] W_SET     = 2'd3;

  logic [N_IRQ-1:0]    sync_out;
  logic [N_IRQ-1:0]    prev_reg;
  logic [N_IRQ-1:0]    pending_reg, pending_next;
  logic [N_IRQ-1:0]    mask_reg;
  logic [N_IRQ-1:0]    edge_reg;
  logic [N_IRQ-1:0]    rise;
  logic [N_IRQ-1:0]    request;
  logic [N_IRQ-1:0]    active;
  logic [N_IRQ-1:0]    ack_clr;
  logic [N_IRQ-1:0]    set_vec;
  logic [N_IRQ-1:0]    clr_vec;
  logic [ID_WIDTH-1:0] enc_id;
  logic                irq_reg;
  logic [ID_WIDTH-1:0] irq_id_reg;
  logic                rvalid_reg;
  logic [31:0]         rdata_reg, rdata_next;
  logic                wr_en, rd_en;
  logic [1:0]          word;
  logic                unused_addr;

  // Synchroniser chain: stage 0 samples the raw input, the last stage is s.
  genvar gi;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_out = irq_i;
    end else begin : g_sync
      logic [N_IRQ-1:0] sync_reg [SYNC_STAGES];
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= '0;
          else if (gi == 0) sync_reg[gi] <= irq_i;
          else sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
      assign sync_out = sync_reg[SYNC_STAGES-1];
    end

    // Ack ids at or beyond N_IRQ match no bit and are therefore ignored.
    for (gi = 0; gi < N_IRQ; gi++) begin : g_ack
      assign ack_clr[gi] = irq_ack_i && (irq_ack_id_i == ID_WIDTH'(gi));
    end
  endgenerate

  assign word  = bus.reg_addr_i[3:2];
  assign wr_en = bus.reg_req_i & bus.reg_we_i;
  assign rd_en = bus.reg_req_i & ~bus.reg_we_i;
  assign unused_addr = ^bus.reg_addr_i[1:0];

  // prev resets to 0, so a source high across reset release is one edge.
  assign rise    = sync_out & ~prev_reg;
  assign request = pending_reg | (~edge_reg & sync_out);
  assign active  = request & mask_reg;

  assign set_vec = (edge_reg & rise)
                 | ((wr_en && word == W_SET) ? bus.reg_wdata_i[N_IRQ-1:0] : '0);
  assign clr_vec = ack_clr
                 | ((wr_en && word == W_PENDING) ? bus.reg_wdata_i[N_IRQ-1:0] : '0);
  // Set wins over clear so a new edge coinciding with an ack is not lost.
  assign pending_next = (pending_reg & ~clr_vec) | set_vec;

  // Ascending scan: the last hit, i.e. the highest index, wins.
  always_comb begin
    enc_id = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (active[i]) enc_id = ID_WIDTH'(i);
    end
  end

  always_comb begin
    rdata_next = '0;
    if (rd_en) begin
      case (word)
        W_PENDING: rdata_next[N_IRQ-1:0] = request;
        W_MASK:    rdata_next[N_IRQ-1:0] = mask_reg;
        W_EDGE:    rdata_next[N_IRQ-1:0] = edge_reg;
        default:   rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg    <= '0;
      pending_reg <= '0;
      mask_reg    <= MASK_RESET;
      edge_reg    <= EDGE_RESET;
      irq_reg     <= 1'b0;
      irq_id_reg  <= '0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      prev_reg    <= sync_out;
      pending_reg <= pending_next;
      if (wr_en && word == W_MASK) mask_reg <= bus.reg_wdata_i[N_IRQ-1:0];
      if (wr_en && word == W_EDGE) edge_reg <= bus.reg_wdata_i[N_IRQ-1:0];
      irq_reg <= |active;
      // id holds its last value while nothing is active.
      if (|active) irq_id_reg <= enc_id;
      rvalid_reg <= bus.reg_req_i;
      rdata_reg  <= rdata_next;
    end
  end

  assign irq_o            = irq_reg;
  assign irq_id_o         = irq_id_reg;
  assign bus.reg_gnt_o    = bus.reg_req_i;
  assign bus.reg_rvalid_o = rvalid_reg;
  assign bus.reg_rdata_o  = rdata_reg;

endmodule

// File: tb/tb_core_irq_ctrl.sv
module tb_core_irq_ctrl;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq_in = '0;
  logic        irq_out;
  logic [4:0]  irq_id;
  logic        ack = 1'b0;
  logic [4:0]  ack_id = '0;

  int n_vec = 0;
  int n_bad = 0;

  core_irq_ctrl_if bus ();

  core_irq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_i        (irq_in),
    .irq_o        (irq_out),
    .irq_id_o     (irq_id),
    .irq_ack_i    (ack),
    .irq_ack_id_i (ack_id),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The synchronised value seen at clock edge k is simply the input sampled
  // SYNC edges earlier (zero if that sample predates the last reset).
  logic [31:0] in_hist [0:4095];
  int          cyc = 0;
  int          rst_cyc = 0;
  logic [31:0] m_pend = '0, m_mask = '1, m_edge = '0;
  logic        exp_irq = 1'b0, exp_rv = 1'b0;
  logic [4:0]  exp_id = '0;
  logic [31:0] exp_rd = '0;

  function automatic logic [31:0] synced(input int k);
    if (k - SYNC < rst_cyc) return '0;
    return in_hist[k - SYNC];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] s, rise, r, a, setv, clrv;
    logic        wr, found;
    logic [1:0]  w;
    if (!rst_n) begin
      m_pend = '0; m_mask = '1; m_edge = '0;
      exp_irq = 1'b0; exp_id = '0; exp_rv = 1'b0; exp_rd = '0;
      rst_cyc = cyc;
    end else begin
      s    = synced(cyc);
      rise = s & ~synced(cyc - 1);
      r    = m_pend | (~m_edge & s);
      a    = r & m_mask;
      exp_irq = (a != 0);
      found = 1'b0;
      for (int i = 31; i >= 0; i--) begin
        if (!found && a[i]) begin
          exp_id = 5'(i);
          found  = 1'b1;
        end
      end
      w  = bus.reg_addr_i[3:2];
      wr = bus.reg_req_i && bus.reg_we_i;
      exp_rv = bus.reg_req_i;
      exp_rd = '0;
      if (bus.reg_req_i && !bus.reg_we_i)
        exp_rd = (w == 0) ? r : (w == 1) ? m_mask : (w == 2) ? m_edge : 32'h0;
      setv = (m_edge & rise) | ((wr && w == 3) ? bus.reg_wdata_i : 32'h0);
      clrv = (ack ? (32'h1 << ack_id) : 32'h0) | ((wr && w == 0) ? bus.reg_wdata_i : 32'h0);
      m_pend = (m_pend & ~clrv) | setv;
      if (wr && w == 1) m_mask = bus.reg_wdata_i;
      if (wr && w == 2) m_edge = bus.reg_wdata_i;
      if (cyc < 4096) in_hist[cyc] = irq_in;
      cyc++;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("irq_o", {31'h0, irq_out}, {31'h0, exp_irq});
    chk("irq_id_o", {27'h0, irq_id}, {27'h0, exp_id});
    chk("rvalid", {31'h0, bus.reg_rvalid_o}, {31'h0, exp_rv});
    chk("rdata", bus.reg_rdata_o, exp_rd);
    chk("gnt", {31'h0, bus.reg_gnt_o}, {31'h0, bus.reg_req_i});
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic we, input logic [3:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd);
    bus.reg_req_i   = 1'b1;
    bus.reg_we_i    = we;
    bus.reg_addr_i  = addr;
    bus.reg_wdata_i = wd;
    #1;
    chk("gnt_direct", {31'h0, bus.reg_gnt_o}, 32'h1);
    tick(1);
    bus.reg_req_i = 1'b0;
    bus.reg_we_i  = 1'b0;
    chk("rvalid_direct", {31'h0, bus.reg_rvalid_o}, 32'h1);
    rd = bus.reg_rdata_o;
    $display("bus %s addr=%h wdata=%h rdata=%h", we ? "WR" : "RD", addr, wd, rd);
  endtask

  logic [31:0] rd;

  initial begin
    bus.reg_req_i = 1'b0; bus.reg_we_i = 1'b0;
    bus.reg_addr_i = '0;  bus.reg_wdata_i = '0;
    tick(3);
    chk("rst_irq", {31'h0, irq_out}, 32'h0);
    chk("rst_rvalid", {31'h0, bus.reg_rvalid_o}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Level source 3: visible 3 edges after the input changes.
    irq_in = 32'h0000_0008;
    tick(2); chk("lvl_early", {31'h0, irq_out}, 32'h0);
    tick(1); chk("lvl_on", {31'h0, irq_out}, 32'h1);
    chk("lvl_id", {27'h0, irq_id}, 32'd3);
    irq_in = '0;
    tick(2); chk("lvl_hold", {31'h0, irq_out}, 32'h1);
    tick(1); chk("lvl_off", {31'h0, irq_out}, 32'h0);
    chk("id_held", {27'h0, irq_id}, 32'd3);

    // Priority and masking.
    irq_in = 32'h8000_0011;
    tick(3); chk("prio_id", {27'h0, irq_id}, 32'd31);
    bus_op(1'b1, 4'h4, 32'h7FFF_FFFF, rd);
    chk("mask_wr_rdata", rd, 32'h0);
    chk("mask_old_id", {27'h0, irq_id}, 32'd31);
    tick(1); chk("mask_new_id", {27'h0, irq_id}, 32'd4);
    irq_in = '0;
    bus_op(1'b1, 4'h4, 32'hFFFF_FFFF, rd);
    tick(4);

    // Edge mode on source 0 with a one-cycle pulse, then ack.
    bus_op(1'b1, 4'h8, 32'h1, rd);
    irq_in = 32'h1; tick(1); irq_in = '0;
    tick(2); chk("edge_early", {31'h0, irq_out}, 32'h0);
    tick(1); chk("edge_on", {31'h0, irq_out}, 32'h1);
    chk("edge_id", {27'h0, irq_id}, 32'd0);
    bus_op(1'b0, 4'h0, 32'h0, rd); chk("edge_pend", rd, 32'h1);
    ack = 1'b1; ack_id = 5'd0; tick(1); ack = 1'b0;
    tick(1); chk("ack_off", {31'h0, irq_out}, 32'h0);
    bus_op(1'b0, 4'h0, 32'h0, rd); chk("ack_pend", rd, 32'h0);

    // Rise on source 5 coinciding with an ack of 5.
    bus_op(1'b1, 4'h8, 32'h21, rd);
    bus_op(1'b1, 4'hC, 32'h20, rd);
    tick(1); chk("set5_id", {27'h0, irq_id}, 32'd5);
    irq_in = 32'h20; tick(2);
    ack = 1'b1; ack_id = 5'd5; tick(1); ack = 1'b0;
    tick(1); chk("race_ack_irq", {31'h0, irq_out}, 32'h1);
    chk("race_ack_id", {27'h0, irq_id}, 32'd5);
    bus_op(1'b0, 4'h0, 32'h0, rd); chk("race_ack_pend", rd, 32'h20);
    // Rise on source 5 coinciding with a W1C of bit 5.
    irq_in = '0; tick(4);
    irq_in = 32'h20; tick(2);
    bus_op(1'b1, 4'h0, 32'h20, rd);
    tick(1); chk("race_w1c_irq", {31'h0, irq_out}, 32'h1);
    bus_op(1'b0, 4'h0, 32'h0, rd); chk("race_w1c_pend", rd, 32'h20);
    irq_in = '0;
    bus_op(1'b1, 4'h0, 32'h20, rd);
    tick(2); chk("w1c_off", {31'h0, irq_out}, 32'h0);
    bus_op(1'b1, 4'h8, 32'h0, rd);
    tick(3);

    // Software trigger and back-to-back write/read.
    bus_op(1'b1, 4'hC, 32'h0000_0400, rd);
    tick(1); chk("sw_id", {27'h0, irq_id}, 32'd10);
    chk("sw_irq", {31'h0, irq_out}, 32'h1);
    bus_op(1'b1, 4'h0, 32'h0000_0400, rd);
    tick(1); chk("sw_clr", {31'h0, irq_out}, 32'h0);
    bus_op(1'b0, 4'hC, 32'h0, rd); chk("set_reads0", rd, 32'h0);
    bus.reg_req_i = 1'b1; bus.reg_we_i = 1'b1;
    bus.reg_addr_i = 4'h4; bus.reg_wdata_i = 32'h0F;
    tick(1);
    bus.reg_we_i = 1'b0;
    chk("b2b_wr_rdata", bus.reg_rdata_o, 32'h0);
    tick(1);
    bus.reg_req_i = 1'b0;
    chk("b2b_rd_rvalid", {31'h0, bus.reg_rvalid_o}, 32'h1);
    chk("b2b_rd_rdata", bus.reg_rdata_o, 32'h0F);
    $display("bus WR/RD back-to-back addr=4 rdata=%h", bus.reg_rdata_o);
    bus_op(1'b1, 4'h4, 32'hFFFF_FFFF, rd);

    // Async reset with a response in flight.
    irq_in = 32'h8;
    tick(3); chk("pre_rst_irq", {31'h0, irq_out}, 32'h1);
    bus_op(1'b0, 4'h4, 32'h0, rd);
    #2 rst_n = 1'b0;
    #1 chk("async_irq", {31'h0, irq_out}, 32'h0);
    chk("async_rvalid", {31'h0, bus.reg_rvalid_o}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    bus_op(1'b0, 4'h4, 32'h0, rd); chk("rst_mask", rd, 32'hFFFF_FFFF);
    bus_op(1'b0, 4'h8, 32'h0, rd); chk("rst_edge", rd, 32'h0);
    tick(3); chk("post_rst_id", {27'h0, irq_id}, 32'd3);
    irq_in = '0;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
